illum_bcd_conv: RTL and testbench

//  Iterative binary-to-BCD converter (shift-add-3 / double-dabble) for the lux value.

---
 rtl/illum_bcd_conv_pkg.sv | 13 +
 rtl/illum_bcd_conv_add3.sv | 9 +
 rtl/illum_bcd_conv.sv | 134 +++++++++++++
 tb/tb_illum_bcd_conv.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/illum_bcd_conv_pkg.sv
// Shared lux display-path definitions: data widths and converter state encodings.
// Used by the scaling stage, the BCD converter and the display driver.
package illum_bcd_conv_pkg;

    localparam int ILLUM_WIDTH  = 16;
    localparam int ILLUM_DIGITS = 5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } illum_state_e;

endpackage

// File: rtl/illum_bcd_conv_add3.sv
// Double-dabble digit adjust: a BCD digit of 5 or more gets +3 before the next shift.
module illum_bcd_conv_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/illum_bcd_conv.sv
// Iterative binary-to-BCD converter for the lux value, one shift per clock,
// with a leading-zero blank mask for the display driver.
module illum_bcd_conv
    import illum_bcd_conv_pkg::*;
#(
    parameter int WIDTH      = ILLUM_WIDTH,
    parameter int DIGITS     = ILLUM_DIGITS,
    parameter int AUTO_START = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    bin_in,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]   blank_mask
);

    //  state    | meaning
    //  ST_IDLE  | waiting for start (or a new bin_in when AUTO_START); outputs held
    //  ST_SHIFT | WIDTH adjust-and-shift steps; last step publishes the result

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    illum_state_e      state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  last_bin_q, last_bin_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0] mask_q, mask_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [BW-1:0]       acc_adj;
    logic [BW+WIDTH-1:0] cat_sh;
    logic [BW-1:0]       acc_next;
    logic [DIGITS-1:0]   mask_next;
    logic                go;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        illum_bcd_conv_add3 u_add3 (
            .d_i (acc_q[4*g +: 4]),
            .d_o (acc_adj[4*g +: 4])
        );
    end

    // Accumulator and binary operand form one long shift register.
    assign cat_sh   = {acc_adj, shift_q} << 1;
    assign acc_next = cat_sh[BW+WIDTH-1:WIDTH];

    assign go = start | ((AUTO_START != 0) && (bin_in != last_bin_q));

    always_comb begin
        logic any_nz;
        any_nz    = 1'b0;
        mask_next = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz       = any_nz | (acc_next[4*i +: 4] != 4'd0);
            mask_next[i] = any_nz;
        end
        mask_next[0] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        last_bin_d = last_bin_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        mask_d     = mask_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    shift_d    = bin_in;
                    last_bin_d = bin_in;
                    acc_d      = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = cat_sh[WIDTH-1:0];
                acc_d   = acc_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    bcd_d   = acc_next;
                    mask_d  = mask_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            last_bin_q <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            mask_q     <= DIGITS'(1);
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            last_bin_q <= last_bin_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            mask_q     <= mask_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign bcd_out    = bcd_q;
    assign blank_mask = mask_q;

endmodule

// File: tb/tb_illum_bcd_conv.sv
// Directed bench for illum_bcd_conv: manual-start instance plus an AUTO_START instance,
// results checked against a decimal reference model through per-instance scoreboards.
module tb_illum_bcd_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bin0, bin1;
    logic        start0, start1;
    logic        busy0, busy1, done0, done1;
    logic [19:0] bcd0, bcd1;
    logic [4:0]  mask0, mask1;

    int total = 0;
    int bad   = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int exp_done0 = 0;
    logic [19:0] last_bcd0 = '0;
    logic [19:0] pend0 = '0;

    typedef struct {
        logic [19:0] bcd;
        logic [4:0]  mask;
        string       tag;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    illum_bcd_conv #(.WIDTH(16), .DIGITS(5), .AUTO_START(0)) dut0 (
        .clk(clk), .rst(rst), .bin_in(bin0), .start(start0),
        .busy(busy0), .done(done0), .bcd_out(bcd0), .blank_mask(mask0)
    );

    illum_bcd_conv #(.WIDTH(16), .DIGITS(5), .AUTO_START(1)) dut1 (
        .clk(clk), .rst(rst), .bin_in(bin1), .start(start1),
        .busy(busy1), .done(done1), .bcd_out(bcd1), .blank_mask(mask1)
    );

    function automatic logic [19:0] bcd_of(input int v);
        logic [19:0] r;
        int x;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] mask_of(input int v);
        logic [4:0] m;
        int p;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            m[i] = (i == 0) || (v >= p);
            p = p * 10;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && done0 === 1'b1) begin
            done_cnt0++;
            if (q0.size() == 0) begin
                check("dut0_unexpected_done", 32'(done0), 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check({e.tag, "_bcd"}, 32'(bcd0), 32'(e.bcd));
                check({e.tag, "_mask"}, 32'(mask0), 32'(e.mask));
            end
        end
        if (rst === 1'b1 && done1 === 1'b1) begin
            done_cnt1++;
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", 32'(done1), 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check({e.tag, "_bcd"}, 32'(bcd1), 32'(e.bcd));
                check({e.tag, "_mask"}, 32'(mask1), 32'(e.mask));
            end
        end
    end

    // Called at a falling edge; leaves start asserted across exactly one rising edge.
    task automatic pulse0(input logic [15:0] v, input bit push, input string tag);
        bin0   = v;
        start0 = 1'b1;
        if (push) begin
            q0.push_back('{bcd_of(int'(v)), mask_of(int'(v)), tag});
            pend0 = bcd_of(int'(v));
            exp_done0++;
        end
        @(negedge clk);
        start0 = 1'b0;
    endtask

    // Starts one falling edge after acceptance; returns on the falling edge that sees done.
    task automatic wait_done(input string tag, input int intr_at, input logic [15:0] intr_v);
        int n, busyc, chg;
        n = 0; busyc = 0; chg = 0;
        while (done0 !== 1'b1 && n < 40) begin
            if (busy0 === 1'b1) busyc++;
            if (bcd0 !== last_bcd0) chg++;
            @(negedge clk);
            n++;
            start0 = (n == intr_at);
            if (n == intr_at) bin0 = intr_v;
        end
        start0 = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'd16);
        check({tag, "_busy_cycles"}, 32'(busyc), 32'd16);
        check({tag, "_held_while_busy"}, 32'(chg), 32'd0);
        last_bcd0 = pend0;
    endtask

    task automatic run0(input logic [15:0] v, input string tag);
        pulse0(v, 1'b1, tag);
        wait_done(tag, -1, 16'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done0), 32'd0);
        check({tag, "_result_held"}, 32'(bcd0), 32'(bcd_of(int'(v))));
    endtask

    task automatic wait_done1(input string tag);
        int n;
        n = 0;
        while (done1 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd17);
    endtask

    initial begin
        rst    = 1'b0;
        bin0   = '0;
        bin1   = '0;
        start0 = 1'b0;
        start1 = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_bcd", 32'(bcd0), 32'd0);
        check("rst_mask", 32'(mask0), 32'h01);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy0), 32'd0);
        check("post_rst_mask", 32'(mask0), 32'h01);
        check("post_rst_auto_idle", 32'(busy1), 32'd0);

        run0(16'd4660, "v4660");
        run0(16'd65535, "v65535");
        run0(16'd0, "v0");
        run0(16'd9, "v9");
        run0(16'd10, "v10");
        run0(16'd100, "v100");
        for (int i = 0; i < 3; i++) begin
            run0(16'($urandom_range(0, 65535)), $sformatf("rand%0d", i));
        end

        // start while busy is dropped; start in the done cycle is taken
        pulse0(16'd1234, 1'b1, "busy_start_1234");
        wait_done("busy_start_1234", 4, 16'd999);
        pulse0(16'd999, 1'b1, "b2b_999");
        wait_done("b2b_999", -1, 16'd0);
        @(negedge clk);
        check("b2b_done_one_cycle", 32'(done0), 32'd0);

        bin0 = 16'd777;
        repeat (20) @(negedge clk);
        check("no_start_no_conv", 32'(done_cnt0), 32'(exp_done0));

        // reset in the middle of a conversion
        pulse0(16'd4321, 1'b0, "");
        repeat (7) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_done", 32'(done0), 32'd0);
        check("midrst_bcd", 32'(bcd0), 32'd0);
        check("midrst_mask", 32'(mask0), 32'h01);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_bcd0 = '0;
        repeat (20) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt0), 32'(exp_done0));
        check("midrst_bcd_after", 32'(bcd0), 32'd0);
        run0(16'd500, "after_rst_500");

        // AUTO_START instance
        repeat (5) @(negedge clk);
        check("auto_steady_zero", 32'(done_cnt1), 32'd0);
        bin1 = 16'd1000;
        q1.push_back('{bcd_of(1000), mask_of(1000), "auto_1000"});
        wait_done1("auto_1000");
        repeat (30) @(negedge clk);
        check("auto_single_conv", 32'(done_cnt1), 32'd1);
        bin1 = 16'd1001;
        q1.push_back('{bcd_of(1001), mask_of(1001), "auto_1001"});
        wait_done1("auto_1001");
        repeat (30) @(negedge clk);
        check("auto_second_conv", 32'(done_cnt1), 32'd2);
        check("auto_bcd_held", 32'(bcd1), 32'h01001);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("dut0_done_count", 32'(done_cnt0), 32'(exp_done0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
